// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad; resets to the line idle level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, start/stop validation, valid/ready output
// register with single-cycle frame_error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic rx_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 busy_q, busy_d;
  logic                 good_stop;
  logic                 bad_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  // Frame FSM; the baud counter restarts on every state change so each sample
  // point is measured from the edge that entered the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_W'(HALF - 1)) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          if (rx_s) begin
            good_stop = 1'b1;
            state_d   = IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = BRK_WAIT;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output register: a consume and a good stop on the same edge keeps valid high.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = bad_stop;
    ov_d    = 1'b0;
    busy_d  = (state_d != IDLE);
    if (valid_q && data_ready) valid_d = 1'b0;
    if (good_stop) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = fe_q;
  assign overrun     = ov_q;
  assign busy        = busy_q;

endmodule
